// File: rtl/arbiter_rr.sv
// Round-robin arbiter with IDLE/GRANT/RELEASE FSM and fully registered outputs.
// Optional grant hold limit with forced revocation: define ARBITER_RR_TIMEOUT_EN.
module arbiter_rr #(
   parameter  int CLIENT_COUNT = 4,
   parameter  int MAX_HOLD     = 16,
   localparam int ID_W         = $clog2(CLIENT_COUNT)
) (
   input  logic                    clk,
   input  logic                    nRst,
   input  logic [CLIENT_COUNT-1:0] request,
   output logic [CLIENT_COUNT-1:0] grant,
   output logic [ID_W-1:0]         grant_id,
   output logic                    busy,
   output logic                    revoked
);

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   state_t          state;
   logic            ready;
   logic [ID_W-1:0] last;
   logic [ID_W-1:0] pick;
   logic [ID_W-1:0] cand;
   logic            found;

   // Rotating search starting one past the most recent owner, wrapping at CLIENT_COUNT.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int k = 1; k <= CLIENT_COUNT; k++) begin
         cand = ID_W'((int'(last) + k) % CLIENT_COUNT);
         if (!found && request[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

`ifdef ARBITER_RR_TIMEOUT_EN
   logic [7:0] hold_cnt;
   logic       timeout_hit;

   assign timeout_hit = (hold_cnt >= 8'(MAX_HOLD)) && (|(request & ~grant));
`else
   assign revoked = 1'b0;
`endif

   // ready blocks arbitration on the first edge after reset release.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state    <= IDLE;
         ready    <= 1'b0;
         last     <= ID_W'(CLIENT_COUNT - 1);
         grant    <= '0;
         grant_id <= '0;
         busy     <= 1'b0;
`ifdef ARBITER_RR_TIMEOUT_EN
         hold_cnt <= '0;
         revoked  <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments keep every flop reading pre-edge values.
         ready <= 1'b1;
`ifdef ARBITER_RR_TIMEOUT_EN
         revoked <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (ready && found) begin
                  grant    <= CLIENT_COUNT'(1) << pick;
                  grant_id <= pick;
                  busy     <= 1'b1;
                  last     <= pick;
                  state    <= GRANT;
`ifdef ARBITER_RR_TIMEOUT_EN
                  hold_cnt <= '0;
`endif
               end
            end
            GRANT: begin
               if (!request[grant_id]) begin
                  grant    <= '0;
                  grant_id <= '0;
                  busy     <= 1'b0;
                  state    <= RELEASE;
               end
`ifdef ARBITER_RR_TIMEOUT_EN
               else if (timeout_hit) begin
                  grant    <= '0;
                  grant_id <= '0;
                  busy     <= 1'b0;
                  revoked  <= 1'b1;
                  state    <= RELEASE;
               end else if (hold_cnt != 8'hFF) begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
`endif
            end
            RELEASE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
